// File: rtl/wbu_commit_pkg.sv
// Shared core defines and the write-back stage types: the buffered instruction record,
// the buffer occupancy states and the write-back value select.
`ifndef WBU_CORE_DEFINES
`define WBU_CORE_DEFINES
`define ADDR_WIDTH      32
`define DATA_WIDTH      32
`define GPRS_WIDTH      5
`define ARGS_WIDTH      2
`define REG_WR_SRC_X    2'd0
`define REG_WR_SRC_ALU  2'd1
`define REG_WR_SRC_MEM  2'd2
`define REG_WR_SRC_PC   2'd3
`define ADDR_INIT       32'h8000_0000
`define DATA_ZERO       32'h0000_0000
`define GPRS_ZERO       5'd0
`endif

package wbu_commit_pkg;

    localparam int DATA_W = `DATA_WIDTH;
    localparam int ADDR_W = `ADDR_WIDTH;

    typedef struct packed {
        logic                    wr_en;
        logic [`ARGS_WIDTH-1:0]  wr_src;
        logic [`ADDR_WIDTH-1:0]  pc;
        logic [`DATA_WIDTH-1:0]  exu_res;
        logic [`DATA_WIDTH-1:0]  lsu_res;
        logic [`GPRS_WIDTH-1:0]  wr_id;
    } wbu_rec_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} wbu_occ_e;

    localparam wbu_rec_t WBU_REC_CLEAR = '{
        wr_en:   1'b0,
        wr_src:  `REG_WR_SRC_X,
        pc:      '0,
        exu_res: `DATA_ZERO,
        lsu_res: `DATA_ZERO,
        wr_id:   `GPRS_ZERO
    };

    // The link value (pc + 4) is computed at address width, then fitted to data width.
    function automatic logic [`DATA_WIDTH-1:0] sel_wb_data(input wbu_rec_t rec);
        logic [`ADDR_WIDTH-1:0] link;
        link = rec.pc + ADDR_W'(4);
        case (rec.wr_src)
            `REG_WR_SRC_ALU: sel_wb_data = rec.exu_res;
            `REG_WR_SRC_MEM: sel_wb_data = rec.lsu_res;
            `REG_WR_SRC_PC:  sel_wb_data = DATA_W'(link);
            default:         sel_wb_data = `DATA_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/wbu_skid_buf.sv
// Two-entry in-order record buffer with an EMPTY/ONE/FULL occupancy FSM.
// Entry 0 is always the oldest record; a dequeue from FULL shifts entry 1 down.
module wbu_skid_buf
    import wbu_commit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     valid_i,
    output logic     ready_o,
    input  wbu_rec_t rec_i,
    input  logic     deq_i,
    output logic     head_valid_o,
    output wbu_rec_t head_o
);

    wbu_occ_e state_q, state_d;
    wbu_rec_t entry_q [DEPTH];
    wbu_rec_t entry_d [DEPTH];
    logic     enq;

    assign ready_o      = (state_q != FULL);
    assign head_valid_o = (state_q != EMPTY);
    assign head_o       = entry_q[0];
    assign enq          = valid_i & ready_o;

    // NOTE: combinational process uses blocking assignments with every output defaulted first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        case (state_q)
            EMPTY: begin
                if (enq) begin
                    entry_d[0] = rec_i;
                    state_d    = ONE;
                end
            end
            ONE: begin
                if (enq && deq_i) begin
                    entry_d[0] = rec_i;
                end else if (enq) begin
                    entry_d[1] = rec_i;
                    state_d    = FULL;
                end else if (deq_i) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (deq_i) begin
                    entry_d[0] = entry_q[1];
                    state_d    = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // NOTE: the entries are storage but are reset anyway, so a reset leaves no stale record that could be written back.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= WBU_REC_CLEAR;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
        end
    end

endmodule

// File: rtl/wbu_commit.sv
// Write-back commit stage: buffers LSU records, drives the GPR write port under
// register-file backpressure, and reports retired instructions for trace.
module wbu_commit
    import wbu_commit_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int RETIRE_W = 64
) (
    input  logic                    i_sys_clk,
    input  logic                    i_sys_rst,
    input  logic                    i_sys_valid,
    output logic                    o_sys_ready,
    input  logic                    i_idu_ctr_reg_wr_en,
    input  logic [`ARGS_WIDTH-1:0]  i_idu_ctr_reg_wr_src,
    input  logic [`ADDR_WIDTH-1:0]  i_ifu_pc,
    input  logic [`DATA_WIDTH-1:0]  i_exu_res,
    input  logic [`DATA_WIDTH-1:0]  i_lsu_res,
    input  logic [`GPRS_WIDTH-1:0]  i_gpr_wr_id,
    output logic                    o_gpr_wr_en,
    output logic [`GPRS_WIDTH-1:0]  o_gpr_wr_id,
    output logic [`DATA_WIDTH-1:0]  o_gpr_wr_data,
    input  logic                    i_gpr_wr_ready,
    output logic                    o_commit_valid,
    output logic [`ADDR_WIDTH-1:0]  o_commit_pc,
    output logic [RETIRE_W-1:0]     o_retire_cnt,
    output logic                    o_err_src
);

    wbu_rec_t in_rec, head;
    logic     head_valid, need_wr, deq, bad_src;

    logic                   commit_valid_q, commit_valid_d;
    logic [`ADDR_WIDTH-1:0] commit_pc_q, commit_pc_d;
    logic [RETIRE_W-1:0]    retire_cnt_q, retire_cnt_d;
    logic                   err_src_q, err_src_d;

    assign in_rec = '{
        wr_en:   i_idu_ctr_reg_wr_en,
        wr_src:  i_idu_ctr_reg_wr_src,
        pc:      i_ifu_pc,
        exu_res: i_exu_res,
        lsu_res: i_lsu_res,
        wr_id:   i_gpr_wr_id
    };

    wbu_skid_buf #(.DEPTH(DEPTH)) u_buf (
        .clk_i        (i_sys_clk),
        .rst_i        (i_sys_rst),
        .valid_i      (i_sys_valid),
        .ready_o      (o_sys_ready),
        .rec_i        (in_rec),
        .deq_i        (deq),
        .head_valid_o (head_valid),
        .head_o       (head)
    );

    // Writes to x0, non-writing records and unknown-source writes retire without a handshake.
    assign bad_src = head.wr_en & (head.wr_src == `REG_WR_SRC_X);
    assign need_wr = head_valid & head.wr_en & (head.wr_id != `GPRS_ZERO)
                   & (head.wr_src != `REG_WR_SRC_X);
    assign deq     = head_valid & (~need_wr | i_gpr_wr_ready);

    assign o_gpr_wr_en   = need_wr;
    assign o_gpr_wr_id   = head_valid ? head.wr_id : `GPRS_ZERO;
    assign o_gpr_wr_data = head_valid ? sel_wb_data(head) : `DATA_ZERO;

    always_comb begin
        commit_valid_d = deq;
        commit_pc_d    = deq ? head.pc : commit_pc_q;
        retire_cnt_d   = deq ? retire_cnt_q + RETIRE_W'(1) : retire_cnt_q;
        err_src_d      = err_src_q | (deq & bad_src);
    end

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            commit_valid_q <= 1'b0;
            commit_pc_q    <= `ADDR_INIT;
            retire_cnt_q   <= '0;
            err_src_q      <= 1'b0;
        end else begin
            commit_valid_q <= commit_valid_d;
            commit_pc_q    <= commit_pc_d;
            retire_cnt_q   <= retire_cnt_d;
            err_src_q      <= err_src_d;
        end
    end

    assign o_commit_valid = commit_valid_q;
    assign o_commit_pc    = commit_pc_q;
    assign o_retire_cnt   = retire_cnt_q;
    assign o_err_src      = err_src_q;

endmodule

// File: tb/tb_wbu_commit.sv
// Directed and randomized bench for wbu_commit against a queue-based model of the
// stage: a bounded FIFO of records, in-order retirement, counters and sticky error.
`ifndef WBU_CORE_DEFINES
`define WBU_CORE_DEFINES
`define ADDR_WIDTH      32
`define DATA_WIDTH      32
`define GPRS_WIDTH      5
`define ARGS_WIDTH      2
`define REG_WR_SRC_X    2'd0
`define REG_WR_SRC_ALU  2'd1
`define REG_WR_SRC_MEM  2'd2
`define REG_WR_SRC_PC   2'd3
`define ADDR_INIT       32'h8000_0000
`define DATA_ZERO       32'h0000_0000
`define GPRS_ZERO       5'd0
`endif

module tb_wbu_commit;
    import wbu_commit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_sys_valid, o_sys_ready;
    logic        i_wr_en;
    logic [1:0]  i_wr_src;
    logic [31:0] i_pc, i_exu, i_lsu;
    logic [4:0]  i_id;
    logic        o_gpr_wr_en;
    logic [4:0]  o_gpr_wr_id;
    logic [31:0] o_gpr_wr_data;
    logic        i_gpr_wr_ready;
    logic        o_commit_valid;
    logic [31:0] o_commit_pc;
    logic [63:0] o_retire_cnt;
    logic        o_err_src;

    always #5 clk = ~clk;

    wbu_commit #(.DEPTH(2), .RETIRE_W(64)) dut (
        .i_sys_clk            (clk),
        .i_sys_rst            (rst),
        .i_sys_valid          (i_sys_valid),
        .o_sys_ready          (o_sys_ready),
        .i_idu_ctr_reg_wr_en  (i_wr_en),
        .i_idu_ctr_reg_wr_src (i_wr_src),
        .i_ifu_pc             (i_pc),
        .i_exu_res            (i_exu),
        .i_lsu_res            (i_lsu),
        .i_gpr_wr_id          (i_id),
        .o_gpr_wr_en          (o_gpr_wr_en),
        .o_gpr_wr_id          (o_gpr_wr_id),
        .o_gpr_wr_data        (o_gpr_wr_data),
        .i_gpr_wr_ready       (i_gpr_wr_ready),
        .o_commit_valid       (o_commit_valid),
        .o_commit_pc          (o_commit_pc),
        .o_retire_cnt         (o_retire_cnt),
        .o_err_src            (o_err_src)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: outstanding records oldest-first, plus the trace outputs.
    wbu_rec_t    mq[$];
    logic        m_cv;
    logic [31:0] m_cpc;
    logic [63:0] m_cnt;
    logic        m_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_data(input wbu_rec_t r);
        if (r.wr_src == `REG_WR_SRC_ALU)      return r.exu_res;
        else if (r.wr_src == `REG_WR_SRC_MEM) return r.lsu_res;
        else if (r.wr_src == `REG_WR_SRC_PC)  return r.pc + 32'd4;
        else                                  return 32'd0;
    endfunction

    task automatic model_clear();
        mq.delete();
        m_cv  = 1'b0;
        m_cpc = `ADDR_INIT;
        m_cnt = '0;
        m_err = 1'b0;
    endtask

    // One clock cycle starting at a negedge: drive, check, let the edge pass, advance model.
    task automatic cycle(input logic v, input logic we, input logic [1:0] s,
                         input logic [31:0] p, input logic [31:0] e, input logic [31:0] l,
                         input logic [4:0] id, input logic gr);
        wbu_rec_t h, r;
        logic     has, need, do_deq, do_enq;
        i_sys_valid = v; i_wr_en = we; i_wr_src = s; i_pc = p;
        i_exu = e; i_lsu = l; i_id = id; i_gpr_wr_ready = gr;
        #1;
        has  = (mq.size() > 0);
        h    = has ? mq[0] : WBU_REC_CLEAR;
        need = has && h.wr_en && (h.wr_id != 5'd0) && (h.wr_src != `REG_WR_SRC_X);
        check("sys_ready",    o_sys_ready,    mq.size() < 2);
        check("gpr_wr_en",    o_gpr_wr_en,    need);
        check("gpr_wr_id",    o_gpr_wr_id,    has ? h.wr_id : 5'd0);
        check("gpr_wr_data",  o_gpr_wr_data,  has ? ref_data(h) : 32'd0);
        check("commit_valid", o_commit_valid, m_cv);
        check("commit_pc",    o_commit_pc,    m_cpc);
        check("retire_cnt",   o_retire_cnt,   m_cnt);
        check("err_src",      o_err_src,      m_err);
        do_deq = has && (!need || gr);
        do_enq = v && (mq.size() < 2);
        r = '{wr_en: we, wr_src: s, pc: p, exu_res: e, lsu_res: l, wr_id: id};
        @(posedge clk);
        m_cv = do_deq;
        if (do_deq) begin
            m_cpc = h.pc;
            m_cnt = m_cnt + 1;
            if (h.wr_en && h.wr_src == `REG_WR_SRC_X) m_err = 1'b1;
            void'(mq.pop_front());
        end
        if (do_enq) mq.push_back(r);
        @(negedge clk);
    endtask

    task automatic idle(input logic gr);
        cycle(1'b0, 1'b0, `REG_WR_SRC_X, 32'd0, 32'd0, 32'd0, 5'd0, gr);
    endtask

    task automatic check_reset_values();
        check("rst_sys_ready",    o_sys_ready,    1'b1);
        check("rst_gpr_wr_en",    o_gpr_wr_en,    1'b0);
        check("rst_gpr_wr_id",    o_gpr_wr_id,    5'd0);
        check("rst_gpr_wr_data",  o_gpr_wr_data,  32'd0);
        check("rst_commit_valid", o_commit_valid, 1'b0);
        check("rst_commit_pc",    o_commit_pc,    `ADDR_INIT);
        check("rst_retire_cnt",   o_retire_cnt,   64'd0);
        check("rst_err_src",      o_err_src,      1'b0);
    endtask

    initial begin
        rst = 1'b1;
        i_sys_valid = 0; i_wr_en = 0; i_wr_src = `REG_WR_SRC_X; i_pc = 0;
        i_exu = 0; i_lsu = 0; i_id = 0; i_gpr_wr_ready = 0;
        model_clear();
        repeat (2) @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        idle(1'b1);

        // Back-to-back ALU writes with the register file always ready.
        cycle(1, 1, `REG_WR_SRC_ALU, 32'h8000_0000, 32'h11, 32'h0, 5'd5, 1);
        cycle(1, 1, `REG_WR_SRC_ALU, 32'h8000_0004, 32'h22, 32'h0, 5'd6, 1);
        idle(1'b1);
        idle(1'b1);
        check("stream_retire_cnt", o_retire_cnt, 64'd2);

        // Backpressure: two accepted, third refused until one cycle after ready returns.
        cycle(1, 1, `REG_WR_SRC_ALU, 32'h8000_0100, 32'hA1, 32'h0,  5'd7, 0);
        cycle(1, 1, `REG_WR_SRC_MEM, 32'h8000_0104, 32'h0,  32'hB2, 5'd8, 0);
        cycle(1, 1, `REG_WR_SRC_ALU, 32'h8000_0108, 32'hC3, 32'h0,  5'd9, 0);
        cycle(1, 1, `REG_WR_SRC_ALU, 32'h8000_0108, 32'hC3, 32'h0,  5'd9, 0);
        check("stall_sys_ready", o_sys_ready, 1'b0);
        cycle(1, 1, `REG_WR_SRC_ALU, 32'h8000_0108, 32'hC3, 32'h0,  5'd9, 1);
        cycle(1, 1, `REG_WR_SRC_ALU, 32'h8000_0108, 32'hC3, 32'h0,  5'd9, 1);
        idle(1'b1);
        idle(1'b1);

        // JAL-style link write.
        cycle(1, 1, `REG_WR_SRC_PC, 32'h8000_0010, 32'h0, 32'h0, 5'd1, 0);
        check("jal_link_data", o_gpr_wr_data, 32'h8000_0014);
        idle(1'b1);
        idle(1'b1);

        // x0 write and a store retire while the register file is stalled.
        cycle(1, 1, `REG_WR_SRC_ALU, 32'h8000_0200, 32'h55, 32'h0, 5'd0, 0);
        cycle(1, 0, `REG_WR_SRC_MEM, 32'h8000_0204, 32'h0,  32'h66, 5'd3, 0);
        idle(1'b0);
        idle(1'b0);

        // Write with unknown source: suppressed, retired, sticky error.
        cycle(1, 1, `REG_WR_SRC_X, 32'h8000_0300, 32'h77, 32'h88, 5'd4, 0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        check("err_src_sticky", o_err_src, 1'b1);

        // Randomized traffic with random register-file backpressure.
        for (int i = 0; i < 400; i++) begin
            logic [4:0] rid;
            rid = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0),
                  2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, rid,
                  1'($urandom_range(0, 9) < 6));
        end

        // Reset with both entries occupied, asserted between clock edges.
        cycle(1, 1, `REG_WR_SRC_ALU, 32'h8000_0400, 32'h1, 32'h0, 5'd10, 0);
        cycle(1, 1, `REG_WR_SRC_ALU, 32'h8000_0404, 32'h2, 32'h0, 5'd11, 0);
        cycle(0, 0, `REG_WR_SRC_X, 32'h0, 32'h0, 32'h0, 5'd0, 0);
        #2 rst = 1'b1;
        #1;
        check_reset_values();
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        idle(1'b1);
        cycle(1, 1, `REG_WR_SRC_MEM, 32'h8000_0500, 32'h0, 32'h99, 5'd12, 1);
        idle(1'b1);
        idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
